ram_arb2: RTL
=============

Name: ram_arb2

Overview:
- Two-requester round-robin arbiter in front of the single-port block RAM (32x8 default).
- Each requester uses a valid/ready request channel and a response channel that cannot be stalled.
- The block owns the RAM's ena/wea/addra/dina, issues at most one access per cycle, and routes read data back to the issuing requester.
- It replaces the single fixed read/write sequencer so that two clients can share one RAM instance.

Parameters:
- ADDR_W, 5: RAM address width.
- DATA_W, 8: RAM data width.
- RD_LAT, 1: RAM read latency in cycles from the sampled ena to valid douta; legal values are 1 and 2.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  asynchronous reset, active-high.
- req0_valid  in  1  requester 0 has an access pending.
- req0_ready  out  1  requester 0 access accepted this cycle.
- req0_we  in  1  1 = write, 0 = read.
- req0_addr  in  ADDR_W  access address.
- req0_wdata  in  DATA_W  write data.
- rsp0_valid  out  1  response pulse for requester 0.
- rsp0_rdata  out  DATA_W  read data for requester 0.
- req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata: same as requester 0, for requester 1.
- ram_en  out  1  to RAM ena.
- ram_we  out  1  to RAM wea.
- ram_addr  out  ADDR_W  to RAM addra.
- ram_wdata  out  DATA_W  to RAM dina.
- ram_rdata  in  DATA_W  from RAM douta.

Behaviour:
- Reset values: all ready, rsp_valid, rsp_rdata and ram_* outputs are 0; last_grant = 1, so requester 0 wins first; the tag pipeline is cleared.
- Acceptance:
  - reqN_ready is combinational from req0_valid, req1_valid and last_grant.
  - At most one ready is high per cycle, and ready is never high without the matching valid.
  - The block is fully pipelined, so a request is accepted every cycle while any valid is high.
- Arbitration:
  - Only one valid high: that requester is granted.
  - Both valid high: the requester not equal to last_grant is granted.
  - last_grant updates only on a grant.
- Issue:
  - Request accepted in cycle T: ram_en=1, ram_we, ram_addr and ram_wdata are registered and driven in T+1.
  - ram_en=0 in any cycle following no acceptance.
- Tag pipeline:
  - Depth RD_LAT+1, carrying {valid, is_read, id}.
  - A read's data is sampled from ram_rdata in cycle T+1+RD_LAT and registered onto rspN_rdata.
  - rspN_valid=1 for exactly one cycle in T+2+RD_LAT, so total read latency = RD_LAT+2 cycles.
- Response data:
  - rspN_rdata holds its value until the next response to that requester.
  - The other requester's rsp_valid stays 0.
- Writes: no response unless the optional feature is enabled.
- Ordering: responses return in issue order; the single port gives no reordering.
- Read-after-write to the same address: the read returns the RAM's native behaviour. The arbiter adds no forwarding and no hazard stall.
- Request-channel stability: a requester must hold valid, we, addr and wdata until it sees ready. A withdrawn request is legal and is simply not granted.
- Reset mid-operation: in-flight tags are discarded and no responses are produced for them. ram_en drops asynchronously.
- Address: no range check; the full ADDR_W range wraps naturally inside the RAM.

Optional Feature:
- Macro: RAM_ARB_WR_ACK_EN.
- Defined:
  - Writes also generate rspN_valid at the same latency as reads (T+2+RD_LAT).
  - rspN_rdata is driven to 0 for the write acknowledge.
- Undefined: only reads generate responses, and the tag is_read bit gates rsp_valid.

Decomposition:
- Package ram_arb_pkg:
  - ADDR_W/DATA_W defaults.
  - Requester id typedef (1 bit).
  - Tag struct {valid, is_read, id}.
  - RD_LAT legal-range constants.
- Sub-module rr_arb2: combinational 2-way round-robin picker plus the registered last_grant.
- Tag pipeline, RAM output registers and response demux stay inline in ram_arb2.

Test Plan:
- Single read (RD_LAT=1): req0 writes 0x5A to addr 3, then req0 reads addr 3 -> ram_en pulse at T+1, rsp0_valid at T+3 with rsp0_rdata=0x5A, rsp1_valid stays 0.
- Contention: both valid on every cycle for 6 cycles, both reading -> grants alternate 0,1,0,1,0,1 starting with req0 after reset; responses alternate rsp0/rsp1 every cycle.
- Back-to-back streaming: req1 alone writes addr 0..31 with data = addr+0x10 on consecutive cycles, then reads 0..31 -> 32 consecutive rsp1_valid pulses, rdata 0x10..0x2F in order, with address 31 followed by 0 (wrap).
- RD_LAT=2 build: same read as the first scenario -> rsp0_valid at T+4.
- Reset mid-flight: assert sys_rst one cycle after a read is accepted -> ram_en=0 immediately, no rsp pulse after release, and the next contention grants req0 first.
- RAM_ARB_WR_ACK_EN defined: req0 write to addr 7 -> rsp0_valid at T+3 with rsp0_rdata=0x00. Undefined: no pulse.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared widths, requester id and tag types for the two-port RAM arbiter
package ram_arb_pkg;
    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 8;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;
    typedef logic req_id_t;
    typedef struct packed {
        logic    valid;
        logic    is_read;
        req_id_t id;
    } tag_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin picker with registered last grant (resets to requester 1 so requester 0 wins first)
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic v0,
    input  logic v1,
    output logic g0,
    output logic g1
);
    logic last;
    // grant the lone requester, or the one that did not win last time
    always_comb begin
        g0 = v0 & (~v1 | last);
        g1 = v1 & (~v0 | ~last);
    end
    // remember the winner only when something was granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last <= 1'b1;
        else if (g0 | g1) last <= g1;
    end
endmodule

// File: rtl/ram_arb2.sv
// ram_arb2: round-robin sharing of one single-port RAM by two requesters; define RAM_ARB_WR_ACK_EN to acknowledge writes
module ram_arb2
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
        $error("ram_arb2: RD_LAT must be 1 or 2");
    end
    logic g0, g1, acc, sel_we, fire, hit0, hit1;
    tag_t pipe [RD_LAT+1];
    tag_t t;
    rr_arb2 u_arb (
        .clk(sys_clk),
        .rst(sys_rst),
        .v0(req0_valid),
        .v1(req1_valid),
        .g0(g0),
        .g1(g1)
    );
    // acceptance, selected write flag and response steering from the oldest tag
    always_comb begin
        req0_ready = g0;
        req1_ready = g1;
        acc = g0 | g1;
        sel_we = g1 ? req1_we : req0_we;
        t = pipe[RD_LAT];
`ifdef RAM_ARB_WR_ACK_EN
        fire = t.valid;
`else
        fire = t.valid & t.is_read;
`endif
        hit0 = fire & ~t.id;
        hit1 = fire & t.id;
    end
    // register the granted access onto the RAM port one cycle after acceptance
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ram_en <= 1'b0;
            ram_we <= 1'b0;
            ram_addr <= '0;
            ram_wdata <= '0;
        end else begin
            ram_en <= acc;
            ram_we <= acc & sel_we;
            if (acc) ram_addr <= g1 ? req1_addr : req0_addr;
            if (acc) ram_wdata <= g1 ? req1_wdata : req0_wdata;
        end
    end
    // tag pipeline aligned so the last stage meets the RAM read data
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i <= RD_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= '{valid: acc, is_read: ~sel_we, id: g1};
            for (int i = 1; i <= RD_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    // one-cycle response pulse; data holds until the next response to that requester
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
        end else begin
            rsp0_valid <= hit0;
            rsp1_valid <= hit1;
            if (hit0) rsp0_rdata <= t.is_read ? ram_rdata : '0;
            if (hit1) rsp1_rdata <= t.is_read ? ram_rdata : '0;
        end
    end
endmodule
